// File: rtl/instr_fetch_if.sv
// Instruction-memory read bus between the fetch stage (master) and memory (slave).
// Single outstanding request; the slave answers with a one-cycle ack.
interface instr_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ack);
    modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ack);
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, runs a req/ack read of instruction memory,
// holds the instruction register and exposes its decoded fields to the control FSM.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             fetch_start,
    input  logic             pc_write,
    input  logic             branch,
    input  logic [31:0]      pc_target,
    instr_fetch_if.master    mem,
    output logic [31:0]      pc,
    output logic [31:0]      ir,
    output logic [6:0]       opcode,
    output logic [2:0]       func3,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic             ir_valid,
    output logic             fetch_err,
    output logic             misalign,
    output logic [CNT_W-1:0] fetch_cnt
);

    localparam logic [31:0] IR_NOP   = 32'h0000_0013;
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic             ir_valid_q, ir_valid_d;
    logic             mem_req_q, mem_req_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic             fetch_err_q, fetch_err_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [7:0]       tmo_q, tmo_d;
    logic             pend_vld_q, pend_vld_d;
    logic             pend_branch_q, pend_branch_d;
    logic [31:0]      pend_target_q, pend_target_d;

    logic             ack_take;
    logic             tmo_hit;
    logic             upd_vld;
    logic             upd_branch;
    logic [31:0]      upd_target;

    // State register (also holds the datapath flops)
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            ir_q          <= IR_NOP;
            ir_valid_q    <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 32'h0;
            fetch_err_q   <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_cnt_q   <= '0;
            tmo_q         <= 8'h0;
            pend_vld_q    <= 1'b0;
            pend_branch_q <= 1'b0;
            pend_target_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            ir_valid_q    <= ir_valid_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            fetch_err_q   <= fetch_err_d;
            misalign_q    <= misalign_d;
            fetch_cnt_q   <= fetch_cnt_d;
            tmo_q         <= tmo_d;
            pend_vld_q    <= pend_vld_d;
            pend_branch_q <= pend_branch_d;
            pend_target_q <= pend_target_d;
        end
    end

    // Next-state logic; an ack in the last allowed cycle still wins over the timeout
    always_comb begin
        state_d  = state_q;
        ack_take = 1'b0;
        tmo_hit  = 1'b0;
        case (state_q)
            S_IDLE: if (fetch_start) state_d = S_WAIT;
            S_WAIT: begin
                if (mem.mem_ack) begin
                    ack_take = 1'b1;
                    state_d  = S_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        pc_d          = pc_q;
        ir_d          = ir_q;
        ir_valid_d    = ir_valid_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        fetch_err_d   = fetch_err_q;
        misalign_d    = misalign_q;
        fetch_cnt_d   = fetch_cnt_q;
        tmo_d         = tmo_q;
        pend_vld_d    = pend_vld_q;
        pend_branch_d = pend_branch_q;
        pend_target_d = pend_target_q;
        upd_vld       = 1'b0;
        upd_branch    = 1'b0;
        upd_target    = 32'h0;

        if (state_q == S_IDLE) begin
            upd_vld    = pc_write;
            upd_branch = branch;
            upd_target = pc_target;
            if (fetch_start) begin
                mem_addr_d = pc_q;
                mem_req_d  = 1'b1;
                ir_valid_d = 1'b0;
                tmo_d      = 8'h0;
            end
        end else begin
            tmo_d = tmo_q + 8'h1;
            // Only the most recent pc_write seen during WAIT survives
            if (pc_write) begin
                pend_vld_d    = 1'b1;
                pend_branch_d = branch;
                pend_target_d = pc_target;
            end
            if (state_d == S_IDLE) begin
                upd_vld    = pend_vld_d;
                upd_branch = pend_branch_d;
                upd_target = pend_target_d;
                pend_vld_d = 1'b0;
                mem_req_d  = 1'b0;
            end
            if (ack_take) begin
                ir_d        = mem.mem_rdata;
                ir_valid_d  = 1'b1;
                fetch_cnt_d = fetch_cnt_q + 1'b1;
            end
            if (tmo_hit) fetch_err_d = 1'b1;
        end

        if (upd_vld) begin
            if (!upd_branch)                pc_d = pc_q + 32'd4;
            else if (upd_target[1:0] == 2'b00) pc_d = upd_target;
            else                            misalign_d = 1'b1;
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign pc           = pc_q;
    assign ir           = ir_q;
    assign ir_valid     = ir_valid_q;
    assign fetch_err    = fetch_err_q;
    assign misalign     = misalign_q;
    assign fetch_cnt    = fetch_cnt_q;
    assign opcode       = ir_q[6:0];
    assign rd           = ir_q[11:7];
    assign func3        = ir_q[14:12];
    assign rs1          = ir_q[19:15];
    assign rs2          = ir_q[24:20];

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage sitting directly upstream of the multicycle control FSM.
- Owns the PC register and runs a request/acknowledge read of instruction memory.
- Latches the returned word into the instruction register and drives the decoded fields (opcode, func3, rd, rs1, rs2) that the control FSM consumes.
- Applies PC updates (sequential +4 or branch/jump target) when the control FSM pulses pc_write.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- TIMEOUT, 16, maximum number of cycles in WAIT without mem_ack before the fetch is aborted; valid range 2..255.
- CNT_W, 32, width of the retired-fetch counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- clr  in  1  synchronous active-high reset.
- fetch_start  in  1  pulse from the control FSM requesting a fetch at the current PC.
- pc_write  in  1  pulse requesting a PC update.
- branch  in  1  qualifies pc_write: 1 loads pc_target, 0 loads pc+4.
- pc_target  in  32  branch/jump target address.
- mem_req  out  1  instruction memory read request.
- mem_addr  out  32  read address; equals the PC captured at request issue.
- mem_rdata  in  32  read data; valid only while mem_ack=1.
- mem_ack  in  1  memory acknowledge, 1-cycle pulse.
- pc  out  32  current PC register.
- ir  out  32  instruction register.
- opcode  out  7  ir[6:0].
- func3  out  3  ir[14:12].
- rd  out  5  ir[11:7].
- rs1  out  5  ir[19:15].
- rs2  out  5  ir[24:20].
- ir_valid  out  1  ir holds a freshly fetched word.
- fetch_err  out  1  sticky flag: a fetch timed out.
- misalign  out  1  sticky flag: a branch target was not 4-byte aligned.
- fetch_cnt  out  CNT_W  count of completed fetches.

Behaviour:
- Reset values (clr=1 at a clock edge, from any state, including mid-fetch):
  - pc=RESET_PC; ir=32'h0000_0013 (addi x0,x0,0); ir_valid=0.
  - mem_req=0; mem_addr=0; fetch_err=0; misalign=0; fetch_cnt=0.
  - Pending-PC-update register cleared; state=IDLE.
  - An outstanding mem_ack arriving after reset is ignored.
- Decoded fields are purely combinational slices of ir.
- States:
  - IDLE:
    - fetch_start=1: mem_addr<=pc, mem_req<=1, ir_valid<=0, timeout counter cleared, go to WAIT.
    - fetch_start=0: stay.
  - WAIT:
    - mem_req holds at 1 and mem_addr stays stable.
    - mem_ack=1: ir<=mem_rdata, ir_valid<=1, mem_req<=0, fetch_cnt<=fetch_cnt+1 (wraps modulo 2^CNT_W), go to IDLE.
    - No ack after TIMEOUT cycles in WAIT: mem_req<=0, fetch_err<=1, ir and ir_valid unchanged (ir_valid stays 0), go to IDLE.
- Latency: mem_req rises 1 cycle after fetch_start. With a same-cycle ack (mem_ack in the first WAIT cycle), ir_valid rises 2 cycles after fetch_start.
- fetch_start while in WAIT is ignored; it is not queued.
- PC update (pc_write=1):
  - branch=0: pc<=pc+4, wrapping modulo 2^32.
  - branch=1 and pc_target[1:0]==0: pc<=pc_target.
  - branch=1 and pc_target[1:0]!=0: pc unchanged, misalign<=1.
- pc_write during WAIT:
  - The update is recorded (branch, pc_target) and applied on the cycle the FSM returns to IDLE.
  - Only the last such pulse during one WAIT is kept.
  - mem_addr is never disturbed by it.
- pc_write and fetch_start in the same IDLE cycle:
  - The fetch uses the pre-update pc.
  - pc takes the new value on that same edge.
- fetch_err and misalign clear only on clr.

Test Plan:
- Reset, then fetch_start; memory acks 3 cycles later with 32'h00B50533 → mem_addr=0; ir=32'h00B50533; opcode=7'b0110011; rd=10; rs1=10; rs2=11; func3=0; ir_valid=1; fetch_cnt=1.
- pc=0x10, pc_write with branch=0, then a fetch → pc=0x14 and mem_addr=0x14. Then pc_write with branch=1, pc_target=0x80 → pc=0x80.
- pc_target=0x82, branch=1, pc_write → pc unchanged, misalign=1 and stays 1 until clr.
- fetch_start with no mem_ack for 16 cycles → mem_req drops after cycle 16, fetch_err=1, ir still holds the previous word, ir_valid=0.
- pc_write (branch=1, target 0x40) during WAIT at pc=0x8 → mem_addr stays 0x8 until ack; pc becomes 0x40 on the IDLE return cycle.
- clr asserted mid-WAIT, then a late mem_ack → pc=RESET_PC, ir=32'h13, fetch_cnt=0, and the ack is ignored.
